// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: FSM state codes, request op codes, data width.
package dmem_pkg;
    localparam int DATA_W = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam logic [DATA_W-1:0] FAULT_DATA = 16'hFFFF;
endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, synchronous read into an output register.
// The read register only updates on re, so it holds the last read word between reads.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/data_memory_responder.sv
// Responder for the CPU data-memory strobe interface: IDLE -> WAIT x WAIT_CYCLES -> RESP.
// Optional macro DMEM_BOUNDS_CHECK_EN flags accesses above the implemented address range.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        mem_ready,
    output logic        busy,
    output logic        mem_fault
);
    logic [1:0]           state;
    logic [3:0]           cnt;
    logic                 op_q;
    logic                 fault_q;
    logic                 rd_fault;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_W-1:0]    wdata_q;

    logic                 accept;
    logic                 req_op;
    logic                 req_fault;
    logic                 enter_resp;
    logic                 resp_op;
    logic                 resp_fault;
    logic                 ram_we;
    logic                 ram_re;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [DATA_W-1:0]    ram_rdata;

    assign accept = (state == IDLE) && (mem_read || mem_write);
    assign req_op = mem_write ? OP_WRITE : OP_READ;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign req_fault = (d_addr >> ADDR_BITS) != 16'h0000;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = |(d_addr >> ADDR_BITS);
    assign req_fault      = 1'b0;
`endif

    // The RAM read fires on the edge that enters RESP so d_rdata is valid for the whole RESP cycle.
    // With zero wait states that edge is the accepting edge, so the live request is used there.
    assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd1));
    assign resp_op    = (state == IDLE) ? req_op : op_q;
    assign resp_fault = (state == IDLE) ? req_fault : fault_q;
    assign ram_addr   = (state == IDLE) ? d_addr[ADDR_BITS-1:0] : addr_q;
    assign ram_re     = !rst && enter_resp && (resp_op == OP_READ) && !resp_fault;
    assign ram_we     = !rst && (state == RESP) && (op_q == OP_WRITE) && !fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            op_q     <= OP_READ;
            fault_q  <= 1'b0;
            rd_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= req_op;
                        fault_q <= req_fault;
                        cnt     <= 4'(WAIT_CYCLES);
                        state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            // A faulted read presents FAULT_DATA and leaves the RAM read register untouched.
            if (enter_resp && (resp_op == OP_READ)) begin
                rd_fault <= resp_fault;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= d_addr[ADDR_BITS-1:0];
            wdata_q <= d_wdata;
        end
    end

    dmem_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    assign d_rdata   = rd_fault ? FAULT_DATA : ram_rdata;
    assign mem_ready = (state == RESP);
    assign busy      = (state != IDLE);

`ifdef DMEM_BOUNDS_CHECK_EN
    assign mem_fault = (state == RESP) && fault_q;
`else
    assign mem_fault = 1'b0;
`endif
endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed table, reset/back-to-back sequences, random vs. model.
// Expectations follow DMEM_BOUNDS_CHECK_EN when the bench is compiled with it.
module tb_data_memory_responder;
    localparam int W  = 2;
    localparam int AB = 8;
`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [15:0] d_addr, d_wdata, d_rdata;
    logic        mem_ready, busy, mem_fault;

    logic        rd0, wr0;
    logic [15:0] addr0, wdata0, rdata0;
    logic        ready0, busy0, fault0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] model [256];
    logic [15:0] last_rd;

    always #5 clk = ~clk;

    data_memory_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .mem_ready(mem_ready), .busy(busy), .mem_fault(mem_fault)
    );

    data_memory_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0),
        .d_addr(addr0), .d_wdata(wdata0), .d_rdata(rdata0),
        .mem_ready(ready0), .busy(busy0), .mem_fault(fault0)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One request: drive strobes, measure latency to mem_ready, check response and hold.
    task automatic do_req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] dat,
                          input logic [15:0] exp_rd, input logic exp_f, input string nm);
        int lat;
        @(negedge clk);
        mem_read = r; mem_write = w; d_addr = a; d_wdata = dat;
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        lat = 1;
        check({nm, " busy"}, busy, 1'b1);
        while (!mem_ready && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({nm, " latency"}, lat, W + 1);
        check({nm, " rdata"}, d_rdata, exp_rd);
        check({nm, " fault"}, mem_fault, exp_f);
        @(negedge clk);
        check({nm, " ready_low"}, mem_ready, 1'b0);
        check({nm, " rdata_hold"}, d_rdata, exp_rd);
    endtask

    task automatic model_req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] dat,
                             input string nm);
        logic        f;
        logic [15:0] e;
        f = BOUNDS && (a[15:8] != 8'h00);
        if (w) begin
            e = last_rd;
            if (!f) model[a[7:0]] = dat;
        end else begin
            e = f ? 16'hFFFF : model[a[7:0]];
            last_rd = e;
        end
        do_req(r, w, a, dat, e, f, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        logic        r, w;
        logic [15:0] a, dat;
        logic [7:0]  upper;

        vecs[0] = '{1'b0, 1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 16'h0010, 16'h1234, 16'hBEEF, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 16'h0103, 16'hAAAA, 16'h1234, BOUNDS};
`ifdef DMEM_BOUNDS_CHECK_EN
        vecs[5] = '{1'b1, 1'b0, 16'h0103, 16'h0000, 16'hFFFF, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 16'h0010, 16'h9999, 16'hFFFF, 1'b0};
`else
        vecs[5] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'hAAAA, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'h0010, 16'h9999, 16'hAAAA, 1'b0};
`endif
        vecs[7] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h9999, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 16'h0007, 16'h1111, 16'h9999, 1'b0};

        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; d_addr = '0; d_wdata = '0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset mem_ready", mem_ready, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset mem_fault", mem_fault, 1'b0);
        check("reset d_rdata", d_rdata, 16'h0000);

        for (int i = 0; i < 9; i++) begin
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
                   vecs[i].exp_rdata, vecs[i].exp_fault, $sformatf("vec%0d", i));
        end

        // Reset during WAIT of a write must drop the request entirely.
        @(negedge clk);
        mem_write = 1'b1; d_addr = 16'h0007; d_wdata = 16'h5555;
        @(negedge clk);
        mem_write = 1'b0;
        check("midrst busy_before", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy_after", busy, 1'b0);
        check("midrst rdata_after", d_rdata, 16'h0000);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_ready) pulses++;
        end
        check("midrst no_ready", pulses, 0);
        last_rd = 16'h0000;
        for (int i = 0; i < 256; i++) model[i] = 16'h0000;
        model[8'h07] = 16'h1111;
        do_req(1'b1, 1'b0, 16'h0007, 16'h0000, 16'h1111, 1'b0, "midrst readback");
        last_rd = 16'h1111;

        for (int i = 0; i < 16; i++) begin
            model_req(1'b0, 1'b1, 16'(i), 16'($urandom), $sformatf("init%0d", i));
        end
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            r = w ? ($urandom_range(0, 3) == 0) : 1'b1;
            upper = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            a = {upper, 4'h0, 4'($urandom_range(0, 15))};
            dat = 16'($urandom);
            model_req(r, w, a, dat, $sformatf("rnd%0d", i));
        end

        // Zero wait states with a read held high: a pulse every second cycle.
        @(negedge clk);
        rd0 = 1'b1; addr0 = 16'h0001;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("w0 ready%0d", k), ready0, (k % 2) == 1);
        end
        rd0 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
